mod_n_counter: RTL and testbench
================================

MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 Parameter MODULUS, default 6: count range 0..MODULUS-1; SHALL be >= 2.
REQ-002 Parameter WIDTH, default 4: width of count and load value; SHALL be >= $clog2(MODULUS).
REQ-003 Parameter INIT, default 0: value loaded on reset; SHALL be < MODULUS.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 en_in  input  1  cascade enable from the lower digit; one count step per cycle while high.
REQ-007 key  input  1  mode select: 1 = run, 0 = set (time adjust).
REQ-008 inc  input  1  set-mode increment button, level input, acts on its rising edge.
REQ-009 dir  input  1  run-mode direction: 0 = up, 1 = down.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value to load.
REQ-012 out  output  WIDTH  current count, registered.
REQ-013 en_out  output  1  cascade enable to the next digit, combinational.
REQ-014 mode  output  1  registered mode: 0 = RUN, 1 = SET.

Function
REQ-015 FSM states: RUN, SET; key sampled each cycle; key=0 -> SET, key=1 -> RUN; the new state takes effect on the following cycle.
REQ-016 RUN, dir=0, en_in=1: out==MODULUS-1 -> 0, else out+1.
REQ-017 RUN, dir=1, en_in=1: out==0 -> MODULUS-1, else out-1.
REQ-018 RUN, en_in=0: out holds.
REQ-019 en_out = (state==RUN) & en_in & (out==MODULUS-1 if dir=0, out==0 if dir=1), evaluated in the same cycle.
REQ-020 SET: en_in ignored; en_out=0; on an inc rising edge (inc=1 and previous sampled inc=0), out steps up with wrap MODULUS-1 -> 0 and produces no carry.
REQ-021 inc held high produces exactly one step; an inc edge seen in RUN is discarded.
REQ-022 load=1 in either state: out <= load_val on the next edge; load_val >= MODULUS saturates to MODULUS-1.
REQ-023 Priority: load > count/increment; a simultaneous inc edge is consumed and dropped; en_out is forced to 0 during a load cycle.
REQ-024 A dir change takes effect on the same edge; there is no pipeline latency.
REQ-025 All arithmetic is WIDTH-bit with explicit compare-to-bound; out never leaves 0..MODULUS-1.

Reset
REQ-026 rst=0 asynchronously forces out=INIT, state=RUN (mode=0) and the inc edge register to 0; en_out is therefore 0.
REQ-027 Reset asserted mid-count or mid-set aborts immediately; on release, operation resumes from INIT in RUN on the first rising edge.

Structure
REQ-028 Shared package clock_pkg SHALL hold the mode enum typedef (MODE_RUN, MODE_SET) and the default constants MOD_SEC_TENS=6, MOD_SEC_UNITS=10 and MOD_HR_TENS=3.
REQ-029 One sub-module, edge_detect (registered rising-edge detector with async active-low reset), SHALL be instantiated for inc.
REQ-030 Parameter legality (REQ-001..003) SHALL be checked at elaboration with an assertion.

Verification
REQ-031 MODULUS=6, reset release, key=1, dir=0, en_in=1 for 7 cycles -> out 0,1,2,3,4,5,0; en_out=1 only while out=5.
REQ-032 MODULUS=10, dir=1, en_in=1 from out=0 -> out 9,8,...; en_out=1 only while out=0.
REQ-033 key=0, inc held high for 5 cycles, then 3 single-cycle pulses -> out +4 total; en_out=0 throughout; wrap 5->0 with no carry.
REQ-034 load=1, load_val=9 with MODULUS=6 -> out=5; load coincident with an inc edge -> out=load_val and no extra step.
REQ-035 rst pulled low asynchronously between clock edges while out=3 -> out=INIT immediately; mode=RUN.
REQ-036 Two instances cascaded (10 then 6), en_in of the low digit tied to 1 for 60 cycles -> pair wraps 59->00 and the high en_out pulses once.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock digit counters: mode encoding and the
// default moduli of the seconds/hours digits.
package clock_pkg;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  localparam int unsigned MOD_SEC_TENS  = 6;
  localparam int unsigned MOD_SEC_UNITS = 10;
  localparam int unsigned MOD_HR_TENS   = 3;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise_o is high for the cycle in which sig_i
// is 1 and the value sampled on the previous clock edge was 0.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N clock digit with cascade enable, up/down run mode, a set mode
// stepped by a debounced-level inc button, and a saturating synchronous load.
module mod_n_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = MOD_SEC_TENS,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned INIT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             key,
  input  logic             inc,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             en_out,
  output logic             mode
);

  if (MODULUS < 2 || WIDTH < $clog2(MODULUS) || INIT >= MODULUS) begin : g_param_check
    $fatal(1, "mod_n_counter: illegal MODULUS/WIDTH/INIT combination");
  end

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);

  mode_e            state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             inc_rise;
  logic             at_max, at_zero;

  edge_detect u_inc_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .sig_i  (inc),
    .rise_o (inc_rise)
  );

  assign at_max  = (cnt_q == MaxVal);
  assign at_zero = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MODE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: key is sampled every cycle, new mode applies next cycle.
  always_comb begin
    state_d = key ? MODE_RUN : MODE_SET;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= InitVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Load wins; an inc edge coincident with load or seen in RUN is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (state_q == MODE_RUN) begin
      if (en_in) begin
        if (!dir) begin
          cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
        end else begin
          cnt_d = at_zero ? MaxVal : cnt_q - WIDTH'(1);
        end
      end
    end else if (inc_rise) begin
      cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Outputs.
  always_comb begin
    out    = cnt_q;
    mode   = state_q;
    en_out = (state_q == MODE_RUN) & en_in & ~load & (dir ? at_zero : at_max);
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: mod-6 and mod-10 digits plus a 10/6
// cascade, with hand-computed expected values checked by immediate assertions.
module tb_mod_n_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Mod-6 digit under direct control.
  logic       a_en_in, a_key, a_inc, a_dir, a_load;
  logic [3:0] a_load_val, a_out;
  logic       a_en_out, a_mode;

  // Mod-10 digit with INIT=7.
  logic       b_en_in, b_key, b_inc, b_dir, b_load;
  logic [3:0] b_load_val, b_out;
  logic       b_en_out, b_mode;

  // Cascade: units (mod 10) feeding tens (mod 6).
  logic       casc_en;
  logic [3:0] lo_out, hi_out;
  logic       lo_en_out, hi_en_out, lo_mode, hi_mode;

  int errors = 0;
  int checks = 0;

  mod_n_counter #(.MODULUS(6), .WIDTH(4), .INIT(0)) dut_a (
    .clk(clk), .rst(rst), .en_in(a_en_in), .key(a_key), .inc(a_inc), .dir(a_dir),
    .load(a_load), .load_val(a_load_val), .out(a_out), .en_out(a_en_out), .mode(a_mode)
  );

  mod_n_counter #(.MODULUS(10), .WIDTH(4), .INIT(7)) dut_b (
    .clk(clk), .rst(rst), .en_in(b_en_in), .key(b_key), .inc(b_inc), .dir(b_dir),
    .load(b_load), .load_val(b_load_val), .out(b_out), .en_out(b_en_out), .mode(b_mode)
  );

  mod_n_counter #(.MODULUS(10), .WIDTH(4), .INIT(0)) dut_lo (
    .clk(clk), .rst(rst), .en_in(casc_en), .key(1'b1), .inc(1'b0), .dir(1'b0),
    .load(1'b0), .load_val(4'd0), .out(lo_out), .en_out(lo_en_out), .mode(lo_mode)
  );

  mod_n_counter #(.MODULUS(6), .WIDTH(4), .INIT(0)) dut_hi (
    .clk(clk), .rst(rst), .en_in(lo_en_out), .key(1'b1), .inc(1'b0), .dir(1'b0),
    .load(1'b0), .load_val(4'd0), .out(hi_out), .en_out(hi_en_out), .mode(hi_mode)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int pulses;
    int pair;

    rst = 1'b1;
    a_en_in = 0; a_key = 1; a_inc = 0; a_dir = 0; a_load = 0; a_load_val = 0;
    b_en_in = 0; b_key = 1; b_inc = 0; b_dir = 0; b_load = 0; b_load_val = 0;
    casc_en = 0;
    #1 rst = 1'b0;
    #2;
    chk("rst_a_out", a_out, 0);
    chk("rst_a_mode", a_mode, 0);
    chk("rst_a_en_out", a_en_out, 0);
    chk("rst_b_out_init", b_out, 7);
    #9 rst = 1'b1;

    // Up count 0..5,0 with en_out only at 5.
    a_en_in = 1; a_dir = 0;
    #1;
    e = 0;
    for (int i = 0; i < 7; i++) begin
      chk("a_up_out", a_out, 8'(e));
      chk("a_up_en_out", a_en_out, 8'(e == 5));
      cyc();
      e = (e == 5) ? 0 : e + 1;
    end
    chk("a_up_final", a_out, 1);

    a_en_in = 0;
    cyc(); cyc();
    chk("a_hold_out", a_out, 1);
    chk("a_hold_en_out", a_en_out, 0);

    // Mod-10 down count from 0.
    b_load = 1; b_load_val = 0;
    cyc();
    chk("b_load0", b_out, 0);
    b_load = 0; b_dir = 1; b_en_in = 1;
    #1;
    e = 0;
    for (int i = 0; i < 11; i++) begin
      chk("b_dn_out", b_out, 8'(e));
      chk("b_dn_en_out", b_en_out, 8'(e == 0));
      cyc();
      e = (e == 0) ? 9 : e - 1;
    end
    chk("b_dn_final", b_out, 9);

    // en_out suppressed on a load cycle.
    b_load = 1; b_load_val = 0; b_en_in = 0;
    cyc();
    b_en_in = 1; b_dir = 1; b_load_val = 3;
    #1;
    chk("b_load_en_out", b_en_out, 0);
    cyc();
    chk("b_load3", b_out, 3);
    b_load = 0; b_dir = 0;
    cyc();
    chk("b_dir_up", b_out, 4);
    b_dir = 1;
    cyc();
    chk("b_dir_dn", b_out, 3);
    b_en_in = 0; b_load = 1; b_load_val = 10;
    cyc();
    chk("b_sat10", b_out, 9);
    b_load_val = 15;
    cyc();
    chk("b_sat15", b_out, 9);
    b_load = 0;

    // Set mode: held inc gives one step, pulses give one each, wrap w/o carry.
    a_key = 0; a_en_in = 0;
    cyc();
    chk("a_mode_set", a_mode, 1);
    a_load = 1; a_load_val = 5;
    cyc();
    chk("a_set_load5", a_out, 5);
    a_load = 0; a_en_in = 1;
    #1;
    chk("a_set_en_out_gated", a_en_out, 0);
    a_inc = 1;
    cyc();
    chk("a_set_wrap", a_out, 0);
    chk("a_set_wrap_en_out", a_en_out, 0);
    for (int i = 0; i < 4; i++) cyc();
    chk("a_set_held", a_out, 0);
    for (int i = 0; i < 3; i++) begin
      a_inc = 0;
      cyc();
      a_inc = 1;
      cyc();
      chk("a_set_pulse_en_out", a_en_out, 0);
    end
    chk("a_set_pulses", a_out, 3);

    // Load coincident with an inc edge: load wins, edge is dropped.
    a_inc = 0;
    cyc();
    a_load = 1; a_load_val = 9; a_inc = 1;
    cyc();
    chk("a_load_sat_inc", a_out, 5);
    a_load = 0;
    cyc();
    chk("a_load_no_step", a_out, 5);

    // inc edge in RUN is discarded.
    a_key = 1; a_inc = 0; a_en_in = 0;
    cyc();
    chk("a_mode_run", a_mode, 0);
    a_inc = 1;
    cyc();
    a_key = 0;
    cyc(); cyc();
    chk("a_run_edge_drop_mode", a_mode, 1);
    chk("a_run_edge_drop", a_out, 5);

    // Async reset between edges.
    a_inc = 0; a_load = 1; a_load_val = 3;
    cyc();
    a_load = 0;
    chk("a_pre_rst", a_out, 3);
    #3 rst = 1'b0;
    #1;
    chk("a_async_rst_out", a_out, 0);
    chk("a_async_rst_mode", a_mode, 0);
    chk("b_async_rst_out", b_out, 7);
    #2 rst = 1'b1;
    a_key = 1; a_en_in = 1; a_dir = 0;
    #1;
    cyc();
    chk("a_post_rst", a_out, 1);
    a_en_in = 0;

    // Cascade 10/6: 60 steps wrap 59 -> 00 with one high-digit carry.
    chk("casc_start", 8'(hi_out * 10 + lo_out), 0);
    casc_en = 1;
    #1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      pair = hi_out * 10 + lo_out;
      chk("casc_pair", 8'(pair), 8'(i));
      if (hi_en_out) pulses++;
      cyc();
    end
    chk("casc_wrap", 8'(hi_out * 10 + lo_out), 0);
    chk("casc_pulses", 8'(pulses), 1);
    casc_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
